// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: RAW bubbles, taken-branch squash, HALT drain/freeze.
// Build option: define HAZARD_FWD_EN when the EX/MEM forwarding network is present.
module hazard_ctrl #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned DRAIN_CYC = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       ID_Rs,
  input  logic [2:0]       ID_Rt,
  input  logic             ID_UsesRs,
  input  logic             ID_UsesRt,
  input  logic             ID_nHaltSig,
  input  logic             IDEX_MemRead,
  input  logic             IDEX_RegWrt,
  input  logic [2:0]       IDEX_RD,
  input  logic             EXMEM_RegWrt,
  input  logic [2:0]       EXMEM_RD,
  input  logic             EX_BranchTaken,
  output logic             PC_we,
  output logic             IFID_we,
  output logic             IFID_flush,
  output logic             IDEX_valid,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned DRN_W = (DRAIN_CYC < 3) ? 2 : $clog2(DRAIN_CYC + 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DRN_W-1:0] drn_q, drn_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic ex_match;
  logic raw_stall;

  // Source-operand match against the instruction currently in EX.
  assign ex_match = (ID_UsesRs && (ID_Rs == IDEX_RD)) ||
                    (ID_UsesRt && (ID_Rt == IDEX_RD));

`ifdef HAZARD_FWD_EN
  logic unused_exmem;
  assign unused_exmem = ^{EXMEM_RegWrt, EXMEM_RD};
  // Only a load in EX cannot be forwarded in time.
  assign raw_stall = IDEX_MemRead && IDEX_RegWrt && ex_match;
`else
  logic mem_match;
  logic unused_memread;
  assign unused_memread = IDEX_MemRead;
  assign mem_match = (ID_UsesRs && (ID_Rs == EXMEM_RD)) ||
                     (ID_UsesRt && (ID_Rt == EXMEM_RD));
  // Without forwarding, wait until the writer has left MEM (RF bypasses WB).
  assign raw_stall = (IDEX_RegWrt && ex_match) || (EXMEM_RegWrt && mem_match);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      drn_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drn_q       <= drn_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    drn_d       = drn_q;
    stall_cnt_d = stall_cnt_q;
    PC_we       = 1'b0;
    IFID_we     = 1'b0;
    IFID_flush  = 1'b0;
    IDEX_valid  = 1'b0;
    halted      = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (EX_BranchTaken) begin
          IFID_flush = 1'b1;
          PC_we      = 1'b1;
          IFID_we    = 1'b1;
        end else if (raw_stall) begin
          if (stall_cnt_q != {CNT_W{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
          end
        end else if (!ID_nHaltSig) begin
          IDEX_valid = 1'b1;
          drn_d      = DRN_W'(DRAIN_CYC);
          state_d    = ST_DRAIN;
        end else begin
          PC_we      = 1'b1;
          IFID_we    = 1'b1;
          IDEX_valid = 1'b1;
        end
      end
      ST_DRAIN: begin
        // Freeze once the decremented count reaches 1, so halted rises DRAIN_CYC after issue.
        drn_d = drn_q - DRN_W'(1);
        if (drn_q <= DRN_W'(2)) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Hold every control low while reset is asserted.
    if (!rst_n) begin
      PC_we      = 1'b0;
      IFID_we    = 1'b0;
      IFID_flush = 1'b0;
      IDEX_valid = 1'b0;
      halted     = 1'b0;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed test-plan steps plus randomized traffic vs a reference model.
module tb_hazard_ctrl;

  localparam int DRAIN_CYC = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0] ID_Rs, ID_Rt, IDEX_RD, EXMEM_RD;
  logic ID_UsesRs, ID_UsesRt, ID_nHaltSig;
  logic IDEX_MemRead, IDEX_RegWrt, EXMEM_RegWrt, EX_BranchTaken;

  logic a_pc, a_ifid, a_flush, a_valid, a_halted;
  logic [15:0] a_cnt;
  logic b_pc, b_ifid, b_flush, b_valid, b_halted;
  logic [1:0] b_cnt;

  hazard_ctrl #(.CNT_W(16), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .ID_nHaltSig(ID_nHaltSig), .IDEX_MemRead(IDEX_MemRead), .IDEX_RegWrt(IDEX_RegWrt),
    .IDEX_RD(IDEX_RD), .EXMEM_RegWrt(EXMEM_RegWrt), .EXMEM_RD(EXMEM_RD),
    .EX_BranchTaken(EX_BranchTaken),
    .PC_we(a_pc), .IFID_we(a_ifid), .IFID_flush(a_flush), .IDEX_valid(a_valid),
    .halted(a_halted), .stall_cnt(a_cnt)
  );

  hazard_ctrl #(.CNT_W(2), .DRAIN_CYC(DRAIN_CYC)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .ID_nHaltSig(ID_nHaltSig), .IDEX_MemRead(IDEX_MemRead), .IDEX_RegWrt(IDEX_RegWrt),
    .IDEX_RD(IDEX_RD), .EXMEM_RegWrt(EXMEM_RegWrt), .EXMEM_RD(EXMEM_RD),
    .EX_BranchTaken(EX_BranchTaken),
    .PC_we(b_pc), .IFID_we(b_ifid), .IFID_flush(b_flush), .IDEX_valid(b_valid),
    .halted(b_halted), .stall_cnt(b_cnt)
  );

  int tests = 0;
  int failed = 0;

  // Reference model: cycle index, total stall cycles, cycle at which HALT issued.
  int m_cyc = 0;
  int m_cnt = 0;
  bit m_issued = 1'b0;
  int m_issue_cyc = 0;

  logic e_pc, e_ifid, e_flush, e_valid, e_halted;
  bit e_stall, e_issue;

  function automatic bit raw_now();
    bit ex_m;
    bit mem_m;
    ex_m  = (ID_UsesRs && ID_Rs == IDEX_RD) || (ID_UsesRt && ID_Rt == IDEX_RD);
    mem_m = (ID_UsesRs && ID_Rs == EXMEM_RD) || (ID_UsesRt && ID_Rt == EXMEM_RD);
`ifdef HAZARD_FWD_EN
    return IDEX_MemRead && IDEX_RegWrt && ex_m;
`else
    return (IDEX_RegWrt && ex_m) || (EXMEM_RegWrt && mem_m);
`endif
  endfunction

  task automatic predict();
    {e_pc, e_ifid, e_flush, e_valid, e_halted} = 5'b0;
    e_stall = 1'b0;
    e_issue = 1'b0;
    if (!rst_n) begin
      e_halted = 1'b0;
    end else if (m_issued && (m_cyc >= m_issue_cyc + DRAIN_CYC)) begin
      e_halted = 1'b1;
    end else if (m_issued) begin
      e_halted = 1'b0;
    end else if (EX_BranchTaken) begin
      e_flush = 1'b1; e_pc = 1'b1; e_ifid = 1'b1;
    end else if (raw_now()) begin
      e_stall = 1'b1;
    end else if (!ID_nHaltSig) begin
      e_valid = 1'b1; e_issue = 1'b1;
    end else begin
      e_pc = 1'b1; e_ifid = 1'b1; e_valid = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Called just after a rising edge: check mid-cycle, then advance the model at the next edge.
  task automatic step();
    int ea;
    int eb;
    #2;
    predict();
    ea = (m_cnt > 65535) ? 65535 : m_cnt;
    eb = (m_cnt > 3) ? 3 : m_cnt;
    chk("pc_we",      32'(a_pc),     32'(e_pc));
    chk("ifid_we",    32'(a_ifid),   32'(e_ifid));
    chk("ifid_flush", 32'(a_flush),  32'(e_flush));
    chk("idex_valid", 32'(a_valid),  32'(e_valid));
    chk("halted",     32'(a_halted), 32'(e_halted));
    chk("stall_cnt",  32'(a_cnt),    32'(ea));
    chk("sat_pc_we",  32'(b_pc),     32'(e_pc));
    chk("sat_valid",  32'(b_valid),  32'(e_valid));
    chk("sat_flush",  32'(b_flush),  32'(e_flush));
    chk("sat_halted", 32'(b_halted), 32'(e_halted));
    chk("sat_cnt",    32'(b_cnt),    32'(eb));
    @(posedge clk);
    if (rst_n) begin
      if (e_stall) m_cnt++;
      if (e_issue) begin
        m_issued = 1'b1;
        m_issue_cyc = m_cyc;
      end
      m_cyc++;
    end
    #1;
  endtask

  task automatic model_reset();
    m_cyc = 0; m_cnt = 0; m_issued = 1'b0; m_issue_cyc = 0;
  endtask

  task automatic set_idle();
    ID_Rs = 3'd0; ID_Rt = 3'd0; ID_UsesRs = 1'b0; ID_UsesRt = 1'b0; ID_nHaltSig = 1'b1;
    IDEX_MemRead = 1'b0; IDEX_RegWrt = 1'b0; IDEX_RD = 3'd0;
    EXMEM_RegWrt = 1'b0; EXMEM_RD = 3'd0; EX_BranchTaken = 1'b0;
  endtask

  task automatic set_load_use();
    set_idle();
    IDEX_MemRead = 1'b1; IDEX_RegWrt = 1'b1; IDEX_RD = 3'd3;
    ID_Rs = 3'd3; ID_UsesRs = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    model_reset();
    // Reset held over 3 clocks with a hazard active.
    set_load_use();
    EX_BranchTaken = 1'b1;
    @(posedge clk); #1;
    repeat (3) step();
    rst_n = 1'b1;
    set_idle();
    ID_Rs = 3'd1; ID_UsesRs = 1'b1; IDEX_RD = 3'd2; IDEX_RegWrt = 1'b1;
    step();

`ifdef HAZARD_FWD_EN
    // Load-use: one bubble, then the load sits in MEM and forwarding covers it.
    set_load_use();
    step();
    IDEX_MemRead = 1'b0; IDEX_RegWrt = 1'b0; EXMEM_RegWrt = 1'b1; EXMEM_RD = 3'd3;
    step();
    chk("loaduse_cnt", 32'(a_cnt), 32'd1);
`else
    // ALU RAW without forwarding: bubble while writer is in EX, then in MEM.
    set_idle();
    IDEX_RegWrt = 1'b1; IDEX_RD = 3'd5; ID_Rt = 3'd5; ID_UsesRt = 1'b1;
    step();
    IDEX_RegWrt = 1'b0; EXMEM_RegWrt = 1'b1; EXMEM_RD = 3'd5;
    step();
    EXMEM_RegWrt = 1'b0;
    step();
    chk("aluraw_cnt", 32'(a_cnt), 32'd2);
`endif

    // Branch and stall together: branch wins, no count.
    set_load_use();
    EX_BranchTaken = 1'b1;
    step();
`ifdef HAZARD_FWD_EN
    chk("br_cnt", 32'(a_cnt), 32'd1);
`else
    chk("br_cnt", 32'(a_cnt), 32'd2);
`endif

    // Five more stalls: narrow counter saturates at 3.
    set_load_use();
    repeat (5) step();
    chk("sat_cnt_lit", 32'(b_cnt), 32'd3);
`ifdef HAZARD_FWD_EN
    chk("wide_cnt_lit", 32'(a_cnt), 32'd6);
`else
    chk("wide_cnt_lit", 32'(a_cnt), 32'd7);
`endif

    // HALT: issue, drain, freeze; a later branch has no effect.
    set_idle();
    ID_nHaltSig = 1'b0;
    step();
    ID_nHaltSig = 1'b1;
    repeat (3) step();
    EX_BranchTaken = 1'b1;
    step();
    step();
    chk("halted_lit", 32'(a_halted), 32'd1);

    // Reset while draining returns to RUN immediately.
    rst_n = 1'b0; model_reset(); step();
    rst_n = 1'b1; set_load_use(); step();
    set_idle(); ID_nHaltSig = 1'b0; step();
    ID_nHaltSig = 1'b1; step();
    rst_n = 1'b0; model_reset();
    step();
    chk("rst_drain_cnt", 32'(b_cnt), 32'd0);
    rst_n = 1'b1; set_idle();
    step();
    chk("rst_drain_run", 32'(a_valid), 32'd1);

    // Randomized traffic against the model; reset after each freeze.
    for (int i = 0; i < 600; i++) begin
      ID_Rs = 3'($urandom_range(0, 3));
      ID_Rt = 3'($urandom_range(0, 3));
      IDEX_RD = 3'($urandom_range(0, 3));
      EXMEM_RD = 3'($urandom_range(0, 3));
      ID_UsesRs = 1'($urandom_range(0, 1));
      ID_UsesRt = 1'($urandom_range(0, 1));
      IDEX_MemRead = 1'($urandom_range(0, 1));
      IDEX_RegWrt = 1'($urandom_range(0, 1));
      EXMEM_RegWrt = 1'($urandom_range(0, 1));
      EX_BranchTaken = ($urandom_range(0, 5) == 0);
      ID_nHaltSig = ($urandom_range(0, 39) != 0);
      if (m_issued && (m_cyc > m_issue_cyc + DRAIN_CYC + 2)) begin
        rst_n = 1'b0;
        model_reset();
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
